// File: rtl/tick_mode_register_if.sv
// Bus bundle for tick_mode_register: control/data inputs from the master,
// register contents and flags back from the slave.
interface tick_mode_register_if #(
  parameter int unsigned WIDTH = 32
);
  logic             tick;
  logic             preset;
  logic [1:0]       mode;
  logic [WIDTH-1:0] d;
  logic             shift_in;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_bar;
  logic             carry;
  logic             zero;

  modport master (
    output tick, preset, mode, d, shift_in,
    input  q, q_bar, carry, zero
  );

  modport slave (
    input  tick, preset, mode, d, shift_in,
    output q, q_bar, carry, zero
  );
endinterface

// File: rtl/tick_mode_register.sv
// Multi-mode WIDTH-bit state register: tick-qualified load, modulo
// increment, shift left/right, synchronous preset, registered carry flag.
module tick_mode_register #(
  parameter int unsigned     WIDTH        = 32,
  parameter logic [WIDTH-1:0] PRESET_VALUE = '0,
  parameter logic [WIDTH-1:0] MAX_VALUE    = '1
) (
  input logic clk,
  input logic rst,
  tick_mode_register_if.slave bus
);

  typedef enum logic [1:0] {
    MODE_LOAD = 2'b00,
    MODE_INC  = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_SHR  = 2'b11
  } mode_e;

  logic [WIDTH-1:0] q_r;
  logic             carry_r;
  logic [WIDTH-1:0] q_next;
  logic             carry_next;
  mode_e            mode_sel;

  assign mode_sel = mode_e'(bus.mode);

  // Next-state selection. Shifts are written as shift-and-or so that
  // WIDTH=1 needs no special case: both directions reduce to q <= shift_in.
  always_comb begin
    q_next     = q_r;
    carry_next = 1'b0;
    if (bus.preset) begin
      q_next     = PRESET_VALUE;
      carry_next = 1'b0;
    end else if (bus.tick) begin
      case (mode_sel)
        MODE_LOAD: begin
          q_next     = bus.d;
          carry_next = 1'b0;
        end
        MODE_INC: begin
          if (q_r >= MAX_VALUE) begin
            q_next     = '0;
            carry_next = 1'b1;
          end else begin
            q_next     = q_r + WIDTH'(1);
            carry_next = 1'b0;
          end
        end
        MODE_SHL: begin
          q_next     = (q_r << 1) | WIDTH'(bus.shift_in);
          carry_next = q_r[WIDTH-1];
        end
        MODE_SHR: begin
          q_next     = (q_r >> 1) | (WIDTH'(bus.shift_in) << (WIDTH-1));
          carry_next = q_r[0];
        end
        default: begin
          q_next     = q_r;
          carry_next = 1'b0;
        end
      endcase
    end
  end

  // State register with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_r     <= '0;
      carry_r <= 1'b0;
    end else begin
      q_r     <= q_next;
      carry_r <= carry_next;
    end
  end

  assign bus.q     = q_r;
  assign bus.q_bar = ~q_r;
  assign bus.carry = carry_r;
  assign bus.zero  = (q_r == '0);

endmodule

// File: tb/tb_tick_mode_register.sv
// Bench for tick_mode_register: three instances (32/4/8 bits) share one
// stimulus stream and are checked every cycle against an arithmetic model,
// plus directed literal expectations.
module tb_tick_mode_register;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick = 1'b0;
  logic        preset = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [31:0] d = '0;
  logic        sin = 1'b0;
  logic        run_cmp = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  tick_mode_register_if #(.WIDTH(32)) if32 ();
  tick_mode_register_if #(.WIDTH(4))  if4 ();
  tick_mode_register_if #(.WIDTH(8))  if8 ();

  assign if32.tick = tick;  assign if32.preset = preset; assign if32.mode = mode;
  assign if32.d = d;        assign if32.shift_in = sin;
  assign if4.tick = tick;   assign if4.preset = preset;  assign if4.mode = mode;
  assign if4.d = d[3:0];    assign if4.shift_in = sin;
  assign if8.tick = tick;   assign if8.preset = preset;  assign if8.mode = mode;
  assign if8.d = d[7:0];    assign if8.shift_in = sin;

  tick_mode_register #(.WIDTH(32), .PRESET_VALUE(32'h0040_0000), .MAX_VALUE(32'hFFFF_FFFF))
    dut32 (.clk(clk), .rst(rst), .bus(if32));
  tick_mode_register #(.WIDTH(4), .PRESET_VALUE(4'd5), .MAX_VALUE(4'd9))
    dut4 (.clk(clk), .rst(rst), .bus(if4));
  tick_mode_register #(.WIDTH(8), .PRESET_VALUE(8'h3C), .MAX_VALUE(8'hFF))
    dut8 (.clk(clk), .rst(rst), .bus(if8));

  localparam int unsigned      W   [3] = '{32, 4, 8};
  localparam longint unsigned  MAXV[3] = '{64'hFFFF_FFFF, 64'd9, 64'hFF};
  localparam longint unsigned  PRE [3] = '{64'h0040_0000, 64'd5, 64'h3C};

  longint unsigned m_q[3] = '{0, 0, 0};
  logic            m_c[3] = '{1'b0, 1'b0, 1'b0};

  logic [31:0] got_q[3];
  logic [31:0] got_qb[3];
  logic        got_c[3];
  logic        got_z[3];

  assign got_q[0] = if32.q;          assign got_qb[0] = if32.q_bar;
  assign got_q[1] = 32'(if4.q);      assign got_qb[1] = 32'(if4.q_bar);
  assign got_q[2] = 32'(if8.q);      assign got_qb[2] = 32'(if8.q_bar);
  assign got_c[0] = if32.carry;      assign got_z[0] = if32.zero;
  assign got_c[1] = if4.carry;       assign got_z[1] = if4.zero;
  assign got_c[2] = if8.carry;       assign got_z[2] = if8.zero;

  // Register behaviour from the rules, in plain modular arithmetic.
  function automatic longint unsigned model_next(
    input int unsigned w, input longint unsigned maxv, input longint unsigned pre,
    input longint unsigned q, input logic t, input logic p, input logic [1:0] m,
    input longint unsigned dv, input logic s, output logic c);
    longint unsigned modulus;
    longint unsigned half;
    modulus = 64'd1 << w;
    half    = modulus / 2;
    c = 1'b0;
    if (p) return pre;
    if (!t) return q;
    case (m)
      2'd0: return dv % modulus;
      2'd1: begin
        if (q >= maxv) begin
          c = 1'b1;
          return 0;
        end
        return q + 1;
      end
      2'd2: begin
        c = (q >= half);
        return (q * 2 + longint'(s)) % modulus;
      end
      default: begin
        c = ((q % 2) == 1);
        return q / 2 + longint'(s) * half;
      end
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask

  // Model state advance, mirroring the clear/edge timing of the register.
  always @(posedge clk or posedge rst) begin
    longint unsigned nq;
    logic c;
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        m_q[i] <= 0;
        m_c[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        nq = model_next(W[i], MAXV[i], PRE[i], m_q[i], tick, preset, mode, longint'(d), sin, c);
        m_q[i] <= nq;
        m_c[i] <= c;
      end
    end
  end

  // Cycle-by-cycle comparison of every instance against the model.
  always @(negedge clk) begin
    longint unsigned mask;
    if (run_cmp) begin
      for (int i = 0; i < 3; i++) begin
        mask = (64'd1 << W[i]) - 1;
        chk($sformatf("cmp_q[%0d]", i), got_q[i], 32'(m_q[i]));
        chk($sformatf("cmp_qbar[%0d]", i), got_qb[i], 32'((~m_q[i]) & mask));
        chk($sformatf("cmp_carry[%0d]", i), 32'(got_c[i]), 32'(m_c[i]));
        chk($sformatf("cmp_zero[%0d]", i), 32'(got_z[i]), 32'(m_q[i] == 0));
      end
    end
  end

  task automatic edge_in(input logic t, input logic p, input logic [1:0] m,
                         input logic [31:0] dv, input logic s);
    @(negedge clk);
    tick = t; preset = p; mode = m; d = dv; sin = s;
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    run_cmp = 1'b1;
    #1;
    chk("rst_q", if32.q, 32'h0);
    chk("rst_qbar", if32.q_bar, 32'hFFFF_FFFF);
    chk("rst_zero", 32'(if32.zero), 32'd1);
    chk("rst_carry", 32'(if32.carry), 32'd0);

    // Async reset mid-cycle while holding 0xA5
    edge_in(1, 0, 2'd0, 32'h0000_00A5, 0);
    chk("load_a5", if32.q, 32'h0000_00A5);
    #2 rst = 1'b1;
    #1;
    chk("async_q", if32.q, 32'h0);
    chk("async_qbar", if32.q_bar, 32'hFFFF_FFFF);
    chk("async_zero", 32'(if32.zero), 32'd1);
    chk("async_carry", 32'(if32.carry), 32'd0);
    edge_in(1, 1, 2'd1, 32'h0, 0);
    edge_in(1, 0, 2'd0, 32'h5555_5555, 0);
    chk("held_rst_q", if32.q, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Load then hold
    edge_in(1, 0, 2'd0, 32'h1234_5678, 0);
    chk("load_q", if32.q, 32'h1234_5678);
    for (int i = 0; i < 3; i++) begin
      edge_in(0, 0, 2'd1, 32'hDEAD_BEEF, 1);
      chk("hold_q", if32.q, 32'h1234_5678);
      chk("hold_carry", 32'(if32.carry), 32'd0);
    end

    // Increment wrap at MAX_VALUE=9 on the 4-bit instance
    edge_in(1, 0, 2'd0, 32'd8, 0);
    chk("inc_load8", 32'(if4.q), 32'd8);
    edge_in(1, 0, 2'd1, 32'd0, 0);
    chk("inc_q9", 32'(if4.q), 32'd9);
    chk("inc_c9", 32'(if4.carry), 32'd0);
    edge_in(1, 0, 2'd1, 32'd0, 0);
    chk("inc_wrap_q", 32'(if4.q), 32'd0);
    chk("inc_wrap_c", 32'(if4.carry), 32'd1);
    chk("inc_wrap_z", 32'(if4.zero), 32'd1);
    edge_in(1, 0, 2'd1, 32'd0, 0);
    chk("inc_q1", 32'(if4.q), 32'd1);
    chk("inc_c1", 32'(if4.carry), 32'd0);
    edge_in(1, 0, 2'd0, 32'd12, 0);
    chk("inc_load12", 32'(if4.q), 32'd12);
    edge_in(1, 0, 2'd1, 32'd0, 0);
    chk("over_max_q", 32'(if4.q), 32'd0);
    chk("over_max_c", 32'(if4.carry), 32'd1);

    // 32-bit all-ones wrap
    edge_in(1, 0, 2'd0, 32'hFFFF_FFFF, 0);
    edge_in(1, 0, 2'd1, 32'h0, 0);
    chk("wrap32_q", if32.q, 32'h0);
    chk("wrap32_c", 32'(if32.carry), 32'd1);

    // Shifts on the 8-bit instance
    edge_in(1, 0, 2'd0, 32'h81, 0);
    edge_in(1, 0, 2'd2, 32'h0, 0);
    chk("shl_q", 32'(if8.q), 32'h02);
    chk("shl_c", 32'(if8.carry), 32'd1);
    edge_in(1, 0, 2'd3, 32'h0, 1);
    chk("shr_q", 32'(if8.q), 32'h81);
    chk("shr_c", 32'(if8.carry), 32'd0);
    edge_in(1, 0, 2'd0, 32'h01, 0);
    edge_in(1, 0, 2'd3, 32'h0, 0);
    chk("shr_out_q", 32'(if8.q), 32'h00);
    chk("shr_out_c", 32'(if8.carry), 32'd1);

    // Preset priority, with and without Tick
    edge_in(1, 1, 2'd1, 32'h0, 0);
    chk("preset_q", if32.q, 32'h0040_0000);
    chk("preset_c", 32'(if32.carry), 32'd0);
    chk("preset8_q", 32'(if8.q), 32'h3C);
    edge_in(1, 0, 2'd0, 32'h7, 0);
    edge_in(0, 1, 2'd2, 32'h0, 1);
    chk("preset_notick_q", if32.q, 32'h0040_0000);
    chk("preset_notick_c", 32'(if32.carry), 32'd0);

    // Reset released just before an increment edge
    @(negedge clk);
    rst = 1'b1;
    tick = 1'b1; preset = 1'b0; mode = 2'd1; d = '0; sin = 1'b0;
    #3 rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rel_inc_q", if32.q, 32'h1);
    chk("rel_inc_q4", 32'(if4.q), 32'h1);

    // Reset pulse during a shift sequence restarts it from zero
    edge_in(1, 0, 2'd0, 32'h01, 0);
    edge_in(1, 0, 2'd2, 32'h0, 1);
    edge_in(1, 0, 2'd2, 32'h0, 1);
    chk("seq_q", 32'(if8.q), 32'h07);
    #2 rst = 1'b1;
    #1;
    chk("seq_rst_q", 32'(if8.q), 32'h00);
    rst = 1'b0;
    edge_in(1, 0, 2'd2, 32'h0, 1);
    chk("seq_restart_q", 32'(if8.q), 32'h01);
    chk("seq_restart_c", 32'(if8.carry), 32'd0);

    edge_in(0, 0, 2'd0, 32'h0, 0);
    @(negedge clk);
    #1;
    run_cmp = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
